// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor. An operand pair is
// accepted through a valid/ready handshake. It is pushed LSB first through a
// single full-subtractor cell, one bit per clock, with the borrow held in a
// flop between bits. The registered difference, borrow-out and zero flag are
// then offered through a valid/ready output handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             busy
);

  // The counter must be able to hold WIDTH itself, with at least one bit.
  localparam int CNT_W = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             zero_q, zero_d;

  logic             cell_diff;
  logic             cell_borrow;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor cell on the current LSBs plus the partial result after inserting its output.
  always_comb begin
    cell_diff   = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
    cell_borrow = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
    // The new bit enters at the MSB. This form also works when WIDTH is 1.
    res_next    = (res_q >> 1) | (WIDTH'(cell_diff) << (WIDTH - 1));
  end

  // Sequencing: accept operands, run WIDTH shifts, hold the result until it is consumed.
  always_comb begin
    state_d      = state_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    res_d        = res_q;
    br_d         = br_q;
    cnt_d        = cnt_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    zero_d       = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          br_d    = borrow_in;
          res_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        br_d   = cell_borrow;
        res_d  = res_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // The result registers change only here, on entry to DONE.
          diff_d       = res_next;
          borrow_out_d = cell_borrow;
          zero_d       = (res_next == '0);
          state_d      = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset aborts any operation in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      res_q        <= '0;
      br_q         <= 1'b0;
      cnt_q        <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      res_q        <= res_d;
      br_q         <= br_d;
      cnt_q        <= cnt_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      zero_q       <= zero_d;
    end
  end

  // Handshake and status outputs are decoded from the state only.
  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == DONE);
    busy       = (state_q == SHIFT);
    diff       = diff_q;
    borrow_out = borrow_out_q;
    zero       = zero_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and back-to-back checks of serial_subtractor
// at WIDTH=8 and WIDTH=1, with a scoreboard queue per instance.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       iv8, ir8, bi8, ov8, or8, bo8, z8, bz8;
  logic [7:0] a8, b8, d8;

  logic       iv1, ir1, bi1, ov1, or1, bo1, z1, bz1;
  logic [0:0] a1, b1, d1;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .borrow_in(bi8), .out_valid(ov8), .out_ready(or8), .diff(d8),
    .borrow_out(bo8), .zero(z8), .busy(bz8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .borrow_in(bi1), .out_valid(ov1), .out_ready(or1), .diff(d1),
    .borrow_out(bo1), .zero(z1), .busy(bz1)
  );

  typedef struct {
    logic [7:0] d;
    logic       bo;
    logic       z;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];

  int tests = 0;
  int fails = 0;

  task automatic checkb(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    tests++;
    assert (obs == exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference arithmetic: (a - b - borrow_in) in width+1 bits, MSB is the borrow.
  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                 input logic bin);
    exp_t       e;
    logic [8:0] r8;
    logic [1:0] r1;
    if (w == 1) begin
      r1   = {1'b0, a[0]} - {1'b0, b[0]} - {1'b0, bin};
      e.d  = {7'b0, r1[0]};
      e.bo = r1[1];
      e.z  = (r1[0] == 1'b0);
    end else begin
      r8   = {1'b0, a} - {1'b0, b} - {8'b0, bin};
      e.d  = r8[7:0];
      e.bo = r8[8];
      e.z  = (r8[7:0] == 8'h00);
    end
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Offer one operand pair to the 8-bit instance; returns just after the accept edge.
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    checkb("in_ready_before_accept", ir8, 1'b1);
    iv8 = 1'b1; a8 = a; b8 = b; bi8 = bin;
    q8.push_back(model(8, a, b, bin));
    tick();
    iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bi8 = 1'b0;
  endtask

  // Wait for the 8-bit result, check latency, busy length and value; optionally consume it.
  task automatic finish8(input string tag, input bit rel);
    int   n  = 0;
    int   nb = 0;
    exp_t e;
    while (!ov8 && n < 40) begin
      if (bz8) nb++;
      tick();
      n++;
    end
    checki({tag, "_latency"}, n, 8);
    checki({tag, "_busy_cycles"}, nb, 8);
    checkb({tag, "_busy_low_in_done"}, bz8, 1'b0);
    checkb({tag, "_in_ready_low_in_done"}, ir8, 1'b0);
    if (q8.size() == 0) begin
      checki({tag, "_scoreboard_entry"}, 0, 1);
    end else begin
      e = q8.pop_front();
      check8({tag, "_diff"}, d8, e.d);
      checkb({tag, "_borrow_out"}, bo8, e.bo);
      checkb({tag, "_zero"}, z8, e.z);
      if (rel) begin
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        checkb({tag, "_out_valid_dropped"}, ov8, 1'b0);
        checkb({tag, "_in_ready_back"}, ir8, 1'b1);
        check8({tag, "_diff_held"}, d8, e.d);
      end
    end
  endtask

  initial begin
    int   ovc;
    int   cyc, got8, got1, sent8, sent1, last8, last1;
    exp_t e;

    rst = 1'b1;
    iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bi8 = 1'b0; or8 = 1'b0;
    iv1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;  bi1 = 1'b0; or1 = 1'b0;
    tick();
    tick();

    // Reset state
    checkb("rst_in_ready", ir8, 1'b1);
    checkb("rst_out_valid", ov8, 1'b0);
    checkb("rst_busy", bz8, 1'b0);
    check8("rst_diff", d8, 8'h00);
    checkb("rst_borrow_out", bo8, 1'b0);
    checkb("rst_zero", z8, 1'b0);
    checkb("rst_w1_in_ready", ir1, 1'b1);
    checkb("rst_w1_out_valid", ov1, 1'b0);
    rst = 1'b0;
    tick();

    // Directed operand pairs
    start8(8'h5A, 8'h23, 1'b0); finish8("sub_5a_23", 1'b1);
    check8("sub_5a_23_const", d8, 8'h37);
    start8(8'h10, 8'h20, 1'b0); finish8("sub_10_20", 1'b1);
    checkb("sub_10_20_borrow_const", bo8, 1'b1);
    start8(8'h00, 8'h00, 1'b1); finish8("sub_00_00_b1", 1'b1);
    check8("sub_00_00_b1_const", d8, 8'hFF);
    start8(8'h42, 8'h41, 1'b1); finish8("sub_42_41_b1", 1'b1);
    checkb("sub_42_41_b1_zero_const", z8, 1'b1);

    // Output backpressure with new operands waiting
    start8(8'h80, 8'h01, 1'b0); finish8("bp", 1'b0);
    iv8 = 1'b1; a8 = 8'h33; b8 = 8'h11; bi8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkb("bp_out_valid_stable", ov8, 1'b1);
      check8("bp_diff_stable", d8, 8'h7F);
      checkb("bp_borrow_stable", bo8, 1'b0);
      checkb("bp_in_ready_low", ir8, 1'b0);
    end
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
    checkb("bp_release_in_ready", ir8, 1'b1);
    checkb("bp_release_out_valid", ov8, 1'b0);
    q8.push_back(model(8, 8'h33, 8'h11, 1'b0));
    tick();
    checkb("bp_next_accepted_busy", bz8, 1'b1);
    checkb("bp_next_accepted_in_ready", ir8, 1'b0);
    iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    finish8("bp_next", 1'b1);

    // Asynchronous reset during SHIFT after 4 shifts
    start8(8'hC3, 8'h5A, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    checkb("abort_busy_before_rst", bz8, 1'b1);
    #2 rst = 1'b1;
    #1;
    checkb("abort_in_ready", ir8, 1'b1);
    checkb("abort_out_valid", ov8, 1'b0);
    checkb("abort_busy", bz8, 1'b0);
    check8("abort_diff", d8, 8'h00);
    checkb("abort_borrow_out", bo8, 1'b0);
    checkb("abort_zero", z8, 1'b0);
    q8.delete();
    tick();
    rst = 1'b0;
    ovc = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ov8) ovc++;
    end
    checki("abort_no_out_valid", ovc, 0);
    start8(8'hFF, 8'h01, 1'b0); finish8("after_rst", 1'b1);
    check8("after_rst_const", d8, 8'hFE);

    // Back-to-back random pairs on both widths with both handshakes tied high
    iv8 = 1'b1; or8 = 1'b1; iv1 = 1'b1; or1 = 1'b1;
    cyc = 0; got8 = 0; got1 = 0; sent8 = 0; sent1 = 0; last8 = -1; last1 = -1;
    while ((got8 < 100 || got1 < 100) && cyc < 3000) begin
      if (ov8) begin
        if (q8.size() == 0) begin
          checki("b2b8_scoreboard_entry", 0, 1);
        end else begin
          e = q8.pop_front();
          check8("b2b8_diff", d8, e.d);
          checkb("b2b8_borrow_out", bo8, e.bo);
          checkb("b2b8_zero", z8, e.z);
        end
        if (last8 >= 0) checki("b2b8_interval", cyc - last8, 10);
        last8 = cyc;
        got8++;
      end
      if (ov1) begin
        if (q1.size() == 0) begin
          checki("b2b1_scoreboard_entry", 0, 1);
        end else begin
          e = q1.pop_front();
          checkb("b2b1_diff", d1[0], e.d[0]);
          checkb("b2b1_borrow_out", bo1, e.bo);
          checkb("b2b1_zero", z1, e.z);
        end
        if (last1 >= 0) checki("b2b1_interval", cyc - last1, 3);
        last1 = cyc;
        got1++;
      end
      if (ir8) begin
        if (sent8 < 100) begin
          a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
          q8.push_back(model(8, a8, b8, bi8));
          sent8++;
        end else begin
          iv8 = 1'b0;
        end
      end
      if (ir1) begin
        if (sent1 < 100) begin
          a1 = 1'($urandom); b1 = 1'($urandom); bi1 = 1'($urandom);
          q1.push_back(model(1, {7'b0, a1}, {7'b0, b1}, bi1));
          sent1++;
        end else begin
          iv1 = 1'b0;
        end
      end
      tick();
      cyc++;
    end
    checki("b2b8_result_count", got8, 100);
    checki("b2b1_result_count", got1, 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
